// File: rtl/ocp_master_arbiter.sv
// ocp_master_arbiter: two-requester round-robin arbiter in front of ocp_master_fsm.
// It grants the shared master, issues one read or write request, tracks the burst
// by watching the OCP bus, and returns done/error/read data to the owner.
module ocp_master_arbiter #(
  parameter int MADDR_WIDTH = 64,
  parameter int MDATA_WIDTH = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  // requester 0
  input  logic [MADDR_WIDTH-1:0] req0_address,
  input  logic [9:0]             req0_burst_length,
  input  logic [2:0]             req0_burst_seq,
  input  logic                   req0_read,
  input  logic                   req0_write,
  input  logic [MDATA_WIDTH-1:0] req0_write_data,
  output logic                   req0_grant,
  output logic                   req0_wr_next,
  output logic [MDATA_WIDTH-1:0] req0_read_data,
  output logic                   req0_read_valid,
  output logic                   req0_done,
  output logic                   req0_error,
  // requester 1
  input  logic [MADDR_WIDTH-1:0] req1_address,
  input  logic [9:0]             req1_burst_length,
  input  logic [2:0]             req1_burst_seq,
  input  logic                   req1_read,
  input  logic                   req1_write,
  input  logic [MDATA_WIDTH-1:0] req1_write_data,
  output logic                   req1_grant,
  output logic                   req1_wr_next,
  output logic [MDATA_WIDTH-1:0] req1_read_data,
  output logic                   req1_read_valid,
  output logic                   req1_done,
  output logic                   req1_error,
  // to / from ocp_master_fsm
  output logic [MADDR_WIDTH-1:0] address,
  output logic [9:0]             burst_length,
  output logic [2:0]             burst_seq,
  output logic [MDATA_WIDTH-1:0] write_data,
  output logic                   read_request,
  output logic                   write_request,
  input  logic [MDATA_WIDTH-1:0] read_data,
  // OCP bus monitor
  input  logic [2:0]             MCmd,
  input  logic                   SCmdAccept,
  input  logic [1:0]             SResp,
  input  logic                   SRespLast
);

  localparam logic [2:0] MCMD_WR    = 3'b001;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_FAIL = 2'b10;
  localparam logic [1:0] SRESP_ERR  = 2'b11;
  // The timeout counter starts at 0 in the ISSUE cycle, so a stall of TIMEOUT
  // cycles is detected while the counter holds TIMEOUT-1.
  localparam logic [7:0] TO_LIMIT   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WR_BURST,
    S_RD_BURST,
    S_DONE
  } state_t;

  state_t      r_state, w_next_state;
  logic        r_err, w_next_err;
  logic        r_win;       // 0: requester 0 owns the master, 1: requester 1
  logic        r_is_wr;     // latched opcode of the granted transaction
  logic [9:0]  r_len;       // latched burst length, 0 already mapped to 1
  logic [9:0]  r_beat;      // beats completed in the current burst
  logic [7:0]  r_to_cnt;    // cycles since the last progress
  logic        r_last;      // requester granted most recently

  logic        w_pend0, w_pend1, w_pick1, w_sel_wr;
  logic [9:0]  w_sel_len, w_len_adj, w_beat_inc;
  logic        w_wr_beat, w_rd_beat, w_beat, w_rd_err, w_timeout, w_gnt;

  // Arbitration: the requester not granted last wins a tie; write beats read.
  assign w_pend0    = req0_read | req0_write;
  assign w_pend1    = req1_read | req1_write;
  assign w_pick1    = w_pend1 & (~w_pend0 | ~r_last);
  assign w_sel_wr   = w_pick1 ? req1_write : req0_write;
  assign w_sel_len  = w_pick1 ? req1_burst_length : req0_burst_length;
  assign w_len_adj  = (w_sel_len == 10'd0) ? 10'd1 : w_sel_len;

  // Progress detection on the monitored OCP bus.
  assign w_wr_beat  = (r_state == S_WR_BURST) && (MCmd == MCMD_WR) && SCmdAccept;
  assign w_rd_beat  = (r_state == S_RD_BURST) && (SResp == SRESP_DVA);
  assign w_beat     = w_wr_beat | w_rd_beat;
  assign w_beat_inc = r_beat + 10'd1;
  assign w_rd_err   = (r_state == S_RD_BURST) &&
                      ((SResp == SRESP_ERR) || (SResp == SRESP_FAIL));
  assign w_timeout  = !w_beat && (r_to_cnt == TO_LIMIT);
  assign w_gnt      = (r_state != S_IDLE);

  // State and error-flag register.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_err   <= w_next_err;
    end
  end

  // Next-state logic; a beat is counted before an error or timeout is considered.
  // NOTE: defaults first so no path leaves a variable unassigned (no latches).
  always_comb begin
    w_next_state = r_state;
    w_next_err   = r_err;
    case (r_state)
      S_IDLE: begin
        w_next_err = 1'b0;
        if (w_pend0 || w_pend1) w_next_state = S_ISSUE;
      end
      S_ISSUE: w_next_state = r_is_wr ? S_WR_BURST : S_RD_BURST;
      S_WR_BURST: begin
        if (w_wr_beat && (w_beat_inc == r_len)) begin
          w_next_state = S_DONE;
          w_next_err   = 1'b0;
        end else if (w_timeout) begin
          w_next_state = S_DONE;
          w_next_err   = 1'b1;
        end
      end
      S_RD_BURST: begin
        if (w_rd_err || w_timeout) begin
          w_next_state = S_DONE;
          w_next_err   = 1'b1;
        end else if (w_rd_beat && ((w_beat_inc == r_len) || SRespLast)) begin
          w_next_state = S_DONE;
          w_next_err   = 1'b0;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Transaction context, beat/timeout counters and round-robin history.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_win    <= 1'b0;
      r_is_wr  <= 1'b0;
      r_len    <= 10'd0;
      r_beat   <= 10'd0;
      r_to_cnt <= 8'd0;
      r_last   <= 1'b1;
    end else begin
      if (r_state == S_IDLE) begin
        r_beat   <= 10'd0;
        r_to_cnt <= 8'd0;
        if (w_pend0 || w_pend1) begin
          r_win   <= w_pick1;
          r_is_wr <= w_sel_wr;
          r_len   <= w_len_adj;
        end
      end else if (w_beat) begin
        r_beat   <= w_beat_inc;
        r_to_cnt <= 8'd0;
      end else if (r_state != S_DONE) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end
      if (r_state == S_DONE) r_last <= r_win;
    end
  end

  // Output steering: everything not belonging to the granted requester is 0.
  always_comb begin
    req0_grant      = w_gnt & ~r_win;
    req1_grant      = w_gnt &  r_win;
    address         = '0;
    burst_length    = 10'd0;
    burst_seq       = 3'd0;
    write_data      = '0;
    write_request   = (r_state == S_ISSUE) &  r_is_wr;
    read_request    = (r_state == S_ISSUE) & ~r_is_wr;
    req0_wr_next    = w_wr_beat & ~r_win;
    req1_wr_next    = w_wr_beat &  r_win;
    req0_read_valid = w_rd_beat & ~r_win;
    req1_read_valid = w_rd_beat &  r_win;
    req0_read_data  = req0_read_valid ? read_data : '0;
    req1_read_data  = req1_read_valid ? read_data : '0;
    req0_done       = (r_state == S_DONE) & ~r_win;
    req1_done       = (r_state == S_DONE) &  r_win;
    req0_error      = req0_done & r_err;
    req1_error      = req1_done & r_err;
    if (w_gnt) begin
      address      = r_win ? req1_address : req0_address;
      burst_length = r_len;
      burst_seq    = r_win ? req1_burst_seq : req0_burst_seq;
    end
    if (r_state == S_WR_BURST) write_data = r_win ? req1_write_data : req0_write_data;
  end

endmodule

// File: tb/tb_ocp_master_arbiter.sv
// Directed bench for ocp_master_arbiter with a read-beat scoreboard queue.
module tb_ocp_master_arbiter;

  logic        sys_clk, reset;
  logic [63:0] req0_address, req1_address;
  logic [9:0]  req0_burst_length, req1_burst_length;
  logic [2:0]  req0_burst_seq, req1_burst_seq;
  logic        req0_read, req0_write, req1_read, req1_write;
  logic [7:0]  req0_write_data, req1_write_data;
  logic        req0_grant, req0_wr_next, req0_read_valid, req0_done, req0_error;
  logic        req1_grant, req1_wr_next, req1_read_valid, req1_done, req1_error;
  logic [7:0]  req0_read_data, req1_read_data;
  logic [63:0] address;
  logic [9:0]  burst_length;
  logic [2:0]  burst_seq;
  logic [7:0]  write_data, read_data;
  logic        read_request, write_request;
  logic [2:0]  MCmd;
  logic        SCmdAccept, SRespLast;
  logic [1:0]  SResp;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [9:0] exp_q[$];           // {req1_valid, req0_valid, data} per read beat
  logic [9:0] mon_got, mon_want;
  logic [7:0] rd_vals [4] = '{8'h04, 8'h08, 8'h0C, 8'h20};

  ocp_master_arbiter #(.MADDR_WIDTH(64), .MDATA_WIDTH(8), .TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .req0_address(req0_address), .req0_burst_length(req0_burst_length),
    .req0_burst_seq(req0_burst_seq), .req0_read(req0_read), .req0_write(req0_write),
    .req0_write_data(req0_write_data), .req0_grant(req0_grant), .req0_wr_next(req0_wr_next),
    .req0_read_data(req0_read_data), .req0_read_valid(req0_read_valid),
    .req0_done(req0_done), .req0_error(req0_error),
    .req1_address(req1_address), .req1_burst_length(req1_burst_length),
    .req1_burst_seq(req1_burst_seq), .req1_read(req1_read), .req1_write(req1_write),
    .req1_write_data(req1_write_data), .req1_grant(req1_grant), .req1_wr_next(req1_wr_next),
    .req1_read_data(req1_read_data), .req1_read_valid(req1_read_valid),
    .req1_done(req1_done), .req1_error(req1_error),
    .address(address), .burst_length(burst_length), .burst_seq(burst_seq),
    .write_data(write_data), .read_request(read_request), .write_request(write_request),
    .read_data(read_data), .MCmd(MCmd), .SCmdAccept(SCmdAccept),
    .SResp(SResp), .SRespLast(SRespLast)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_wr(input int who, input logic [9:0] len, input logic [7:0] data,
                        input logic [63:0] addr);
    if (who == 0) begin
      req0_write = 1'b1; req0_burst_length = len; req0_write_data = data; req0_address = addr;
    end else begin
      req1_write = 1'b1; req1_burst_length = len; req1_write_data = data; req1_address = addr;
    end
  endtask

  task automatic drop(input int who);
    if (who == 0) begin req0_read = 1'b0; req0_write = 1'b0; end
    else          begin req1_read = 1'b0; req1_write = 1'b0; end
  endtask

  // Single-beat write: the request is already visible to an IDLE arbiter.
  task automatic wr_single(input int who, input logic [63:0] exp_addr, input logic [7:0] exp_data);
    logic [1:0] sel;
    sel = (who == 0) ? 2'b01 : 2'b10;
    tick(); #1;
    chk("issue_grant", {req1_grant, req0_grant}, sel);
    chk("issue_wreq",  write_request, 1'b1);
    chk("issue_rreq",  read_request, 1'b0);
    chk("issue_addr",  address, exp_addr);
    chk("issue_len",   burst_length, 10'd1);
    tick(); MCmd = 3'b001; SCmdAccept = 1'b1; #1;
    chk("wr_next",     {req1_wr_next, req0_wr_next}, sel);
    chk("wr_data",     write_data, exp_data);
    tick(); MCmd = 3'b000; SCmdAccept = 1'b0; #1;
    chk("wr_done",     {req1_done, req0_done}, sel);
    chk("wr_error",    {req1_error, req0_error}, 2'b00);
    drop(who);
  endtask

  // Scoreboard: every read_valid pulse must match the next queued beat.
  always @(negedge sys_clk) begin
    if (req0_read_valid || req1_read_valid) begin
      mon_got = {req1_read_valid, req0_read_valid,
                 (req1_read_valid ? req1_read_data : req0_read_data)};
      if (exp_q.size() == 0) chk("rd_unexpected", mon_got, 10'd0);
      else begin
        mon_want = exp_q.pop_front();
        chk("rd_beat", mon_got, mon_want);
      end
    end
  end

  initial begin
    reset = 1'b1;
    req0_address = '0; req1_address = '0;
    req0_burst_length = '0; req1_burst_length = '0;
    req0_burst_seq = 3'd2; req1_burst_seq = 3'd5;
    req0_read = 1'b0; req0_write = 1'b0; req1_read = 1'b0; req1_write = 1'b0;
    req0_write_data = '0; req1_write_data = '0;
    read_data = '0; MCmd = '0; SCmdAccept = 1'b0; SResp = '0; SRespLast = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_grant", {req1_grant, req0_grant}, 2'b00);
    chk("rst_req",   {write_request, read_request}, 2'b00);
    chk("rst_done",  {req1_done, req0_done}, 2'b00);
    chk("rst_addr",  address, 64'd0);

    // Single write, all-ones address and data.
    set_wr(0, 10'd1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    #1 chk("idle_grant", req0_grant, 1'b0);
    wr_single(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    tick(); #1;
    chk("post_wr_idle", {req1_grant, req0_grant, req0_done}, 3'b000);

    // Burst read of four beats, last flagged with SRespLast.
    req0_read = 1'b1; req0_burst_length = 10'd4; req0_address = 64'h1000;
    tick(); #1;
    chk("rd_issue", {read_request, write_request, req0_grant}, 3'b101);
    for (int i = 0; i < 4; i++) begin
      tick();
      SResp = 2'b01; read_data = rd_vals[i]; SRespLast = (i == 3);
      exp_q.push_back({2'b01, rd_vals[i]});
    end
    tick(); SResp = 2'b00; SRespLast = 1'b0; read_data = 8'h00; #1;
    chk("rd_done", {req0_done, req0_error}, 2'b10);
    drop(0);
    tick(); #1;
    chk("rd_idle", {req1_grant, req0_grant}, 2'b00);

    // Contention from reset: req0 first, then req1 ahead of a returning req0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_wr(0, 10'd1, 8'hA0, 64'h0A0);
    set_wr(1, 10'd1, 8'hA1, 64'h0A1);
    wr_single(0, 64'h0A0, 8'hA0);
    tick();
    set_wr(0, 10'd1, 8'hB0, 64'h0B0);
    #1 chk("gap_idle", {req1_grant, req0_grant}, 2'b00);
    wr_single(1, 64'h0A1, 8'hA1);
    tick(); #1;
    chk("gap_idle2", {req1_grant, req0_grant}, 2'b00);
    wr_single(0, 64'h0B0, 8'hB0);
    tick();

    // Read on requester 1 with ERR on the second of four beats.
    req1_read = 1'b1; req1_burst_length = 10'd4; req1_address = 64'h2000;
    tick(); #1;
    chk("err_issue", {read_request, req1_grant}, 2'b11);
    tick(); SResp = 2'b01; read_data = 8'h55;
    exp_q.push_back({2'b10, 8'h55});
    tick(); SResp = 2'b11; read_data = 8'h66;
    tick(); SResp = 2'b00; read_data = 8'h00; #1;
    chk("err_done", {req1_done, req1_error}, 2'b11);
    drop(1);
    tick(); #1;
    chk("err_idle", {req1_grant, req0_grant}, 2'b00);

    // Write that is never accepted: timeout after TIMEOUT=8 cycles from ISSUE.
    set_wr(0, 10'd1, 8'h3C, 64'h3000);
    tick(); #1;
    chk("to_issue", write_request, 1'b1);
    repeat (6) tick();
    tick(); #1;
    chk("to_early", req0_done, 1'b0);
    tick(); #1;
    chk("to_done", {req0_done, req0_error}, 2'b11);
    drop(0);
    tick();

    // Reset in the middle of a requester-1 write burst.
    set_wr(1, 10'd4, 8'h77, 64'h4000);
    tick(); #1;
    chk("mid_issue", req1_grant, 1'b1);
    tick(); MCmd = 3'b001; SCmdAccept = 1'b1; #1;
    chk("mid_beat", req1_wr_next, 1'b1);
    tick(); MCmd = 3'b000; SCmdAccept = 1'b0; reset = 1'b1;
    tick(); #1;
    chk("mid_rst_flags", {req1_grant, req0_grant, req1_done, req0_done, req1_error,
                          req0_error, req1_wr_next, req0_wr_next, write_request,
                          read_request}, 10'd0);
    chk("mid_rst_bus", {burst_length, write_data, address[31:0]}, 50'd0);
    reset = 1'b0;
    set_wr(0, 10'd0, 8'h5A, 64'h5000);  // zero length behaves as one beat
    wr_single(0, 64'h5000, 8'h5A);
    drop(1);
    tick(); #1;
    chk("end_idle", {req1_grant, req0_grant, req1_done, req0_done}, 4'b0000);
    chk("sb_empty", exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ocp_master_arbiter.md
# ocp_master_arbiter

Two-requester round-robin arbiter and transaction sequencer sitting between the PCIe-side clients and `ocp_master_fsm`. It grants the shared OCP master to one requester at a time, issues a one-cycle read/write request with that requester's address and burst parameters, and holds the grant until the burst completes. It tracks completion by monitoring the OCP bus: write beats are accepted commands, read beats are DVA responses. It then returns a done/error pulse and read data to the granted requester.

## Interface
- MADDR_WIDTH, 64, address width
- MDATA_WIDTH, 8, data width
- TIMEOUT, 255, max cycles without progress (accept or response) before abort; 8-bit counter
- sys_clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- reqN_address (N=0,1)  in  MADDR_WIDTH  requester address
- reqN_burst_length  in  10  beats; 0 treated as 1
- reqN_burst_seq  in  3  burst sequence code, passed through
- reqN_read / reqN_write  in  1  level request, held until reqN_done
- reqN_write_data  in  MDATA_WIDTH  current write beat
- reqN_grant  out  1  requester owns the master
- reqN_wr_next  out  1  pulse: current write beat accepted, present next
- reqN_read_data  out  MDATA_WIDTH  read beat
- reqN_read_valid  out  1  pulse per read beat
- reqN_done  out  1  one-cycle completion pulse
- reqN_error  out  1  qualifies reqN_done: ERR/FAIL response or timeout
- address, burst_length, burst_seq, write_data, read_request, write_request  out  —  to ocp_master_fsm
- read_data  in  MDATA_WIDTH  from ocp_master_fsm
- MCmd  in  3, SCmdAccept  in  1, SResp  in  2, SRespLast  in  1  OCP bus monitor

## Operation
- States: IDLE, ISSUE, WR_BURST, RD_BURST, DONE.
- IDLE: collect requests (read|write per requester). If both are pending, the requester not granted last wins. The last-grant register resets to 1, so req0 wins first. Latch winner, opcode, and length (0→1). Go to ISSUE.
- Same requester asserting read and write together: write wins; read ignored.
- ISSUE (1 cycle): grant high; drive winner address/burst_length/burst_seq; pulse write_request or read_request; go to WR_BURST or RD_BURST.
- WR_BURST: write_data = winner reqN_write_data (combinational mux). Each cycle with MCmd==WR && SCmdAccept is one beat: pulse reqN_wr_next and increment the 10-bit beat counter. Leave when the counter reaches length → DONE.
- RD_BURST: each SResp==DVA pulses reqN_read_valid with reqN_read_data=read_data and increments the counter. Leave when the count reaches length or DVA arrives with SRespLast=1 → DONE.
- SResp ERR or FAIL in RD_BURST → DONE with error.
- Timeout: counter clears on every beat and in ISSUE. At TIMEOUT cycles with no beat → DONE with error.
- DONE (1 cycle): reqN_done pulse (with reqN_error if applicable); update last-grant; grant drops next cycle; → IDLE. The requester must drop its request on the done edge.
- Ungranted outputs are 0: address, burst_length, burst_seq, write_data, read/write_request, all per-requester pulses and read_data.

## Timing
- Reset (synchronous): state IDLE, all outputs 0, counters 0, last-grant=1. Reset mid-burst aborts silently with no done pulse.
- Request seen in IDLE at cycle N → ISSUE at N+1 (grant=1, request pulse) → burst state at N+2.
- Minimum single-beat write is 4 cycles request→done if SCmdAccept arrives at N+2.
- reqN_done is registered, asserted the cycle after the final beat; grant deasserts with the return to IDLE. Back-to-back grants are separated by one IDLE cycle.
- Requests are ignored outside IDLE. A requester arriving mid-burst waits.
- 10-bit counter compare uses latched length; burst_length 1023 is legal and completes at 1023 beats.
- Beat and error in the same cycle: the beat is counted, then error wins.

## Test plan
- Single write: req0_write, addr FFFF_FFFF_FFFF_FFFF, len 1, data FF, SCmdAccept at N+2 → write_request pulse at N+1, one wr_next, req0_done at N+3, error 0.
- Burst read len 4, DVA data 04,08,0C,20 (last with SRespLast) → four read_valid pulses with those values, done after 20, no error.
- Contention: req0 and req1 both write len 1 at reset → req0 granted first, req1 issued after one IDLE cycle; repeat both → req1 first (round-robin).
- Read with SResp=ERR on beat 2 of 4 → one read_valid, done+error, return to IDLE.
- SCmdAccept never asserted, TIMEOUT=8 → done+error 8 cycles after ISSUE.
- Reset asserted mid-write burst → next cycle all outputs 0, no done; req0 wins next arbitration.
